spi_flash_responder: RTL and testbench

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

---
 rtl/spi_flash_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI (mode 0) serial-flash responder backed by a small byte array: WREN/WRDI/RDSR/READ/PP.
// All SPI pins are resynchronised into clk; the protocol engine runs entirely on clk.
module spi_flash_responder #(
  parameter int MEM_AW      = 8,
  parameter int BUSY_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic wel,
  output logic wip
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam int BCW   = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, RD_STAT, RD_DATA, WR_DATA, IGNORE
  } state_t;

  // WREN/WRDI only commit if the transaction ends after exactly 8 bits.
  typedef enum logic [1:0] {WEL_KEEP, WEL_SET, WEL_CLR} wel_op_t;

  state_t            state;
  wel_op_t           wel_op;
  logic [1:0]        sck_sync, cs_sync, mosi_sync;
  logic              sck_q, cs_q;
  logic              sck_s, cs_s, mosi_s;
  logic              sck_rise, sck_fall, cs_rise, cs_fall;
  logic [4:0]        bit_cnt;
  logic [6:0]        rx_sh;
  logic [7:0]        rx_byte;
  logic [MEM_AW-1:0] ptr;
  logic              is_prog;
  logic              wrote;
  logic [7:0]        tx_sh;
  logic [2:0]        tx_cnt;
  logic [7:0]        tx_next;
  logic [BCW-1:0]    busy_cnt;
  logic              mem_we;

  logic [7:0] mem [DEPTH] = '{default: 8'hFF};

  assign sck_s  = sck_sync[1];
  assign cs_s   = cs_sync[1];
  assign mosi_s = mosi_sync[1];

  assign sck_rise = ~cs_s & sck_s & ~sck_q;
  assign sck_fall = ~cs_s & ~sck_s & sck_q;
  assign cs_fall  = cs_q & ~cs_s;
  assign cs_rise  = ~cs_q & cs_s;

  assign rx_byte = {rx_sh, mosi_s};
  assign tx_next = (state == RD_DATA) ? mem[ptr] : {6'b0, wel, wip};
  assign mem_we  = rst & (state == WR_DATA) & sck_rise & (bit_cnt == 5'd7);

  // NOTE: the array has no reset branch; clearing it would force a flop-based
  // implementation, and its contents must survive rst anyway.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= rx_byte;
  end

  // NOTE: every register below is assigned with <= so all of them see the
  // pre-edge values of each other, exactly like the flops they become.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      state     <= IDLE;
      wel_op    <= WEL_KEEP;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      ptr       <= '0;
      is_prog   <= 1'b0;
      wrote     <= 1'b0;
      tx_sh     <= '0;
      tx_cnt    <= '0;
      busy_cnt  <= '0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      wel       <= 1'b0;
      wip       <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], sck};
      cs_sync   <= {cs_sync[0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
      sck_q     <= sck_s;
      cs_q      <= cs_s;

      // Page-program busy timer; completion also drops the write-enable latch.
      if (wip) begin
        if (busy_cnt == '0) begin
          wip <= 1'b0;
          wel <= 1'b0;
        end else begin
          busy_cnt <= busy_cnt - BCW'(1);
        end
      end

      if (cs_rise) begin
        state   <= IDLE;
        bit_cnt <= '0;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
        wel_op  <= WEL_KEEP;
        if (state == WR_DATA && wrote) begin
          wip      <= 1'b1;
          busy_cnt <= BCW'(BUSY_CYCLES - 1);
        end
        if (wel_op == WEL_SET) wel <= 1'b1;
        else if (wel_op == WEL_CLR) wel <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
              wel_op  <= WEL_KEEP;
            end
          end

          CMD: begin
            if (sck_rise) begin
              rx_sh   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                tx_cnt  <= '0;
                state   <= IGNORE;
                if (rx_byte == OP_RDSR) begin
                  state   <= RD_STAT;
                  miso_oe <= 1'b1;
                end else if (!wip) begin
                  case (rx_byte)
                    OP_WREN: wel_op <= WEL_SET;
                    OP_WRDI: wel_op <= WEL_CLR;
                    OP_READ: begin
                      state   <= ADDR;
                      is_prog <= 1'b0;
                    end
                    OP_PP: begin
                      if (wel) begin
                        state   <= ADDR;
                        is_prog <= 1'b1;
                      end
                    end
                    default: ;
                  endcase
                end
              end
            end
          end

          ADDR: begin
            if (sck_rise) begin
              // Shifting straight into ptr keeps only the low MEM_AW address bits.
              ptr     <= {ptr[MEM_AW-2:0], mosi_s};
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd23) begin
                bit_cnt <= '0;
                if (is_prog) begin
                  state <= WR_DATA;
                  wrote <= 1'b0;
                end else begin
                  state   <= RD_DATA;
                  miso_oe <= 1'b1;
                  tx_cnt  <= '0;
                end
              end
            end
          end

          RD_STAT, RD_DATA: begin
            if (sck_fall) begin
              if (tx_cnt == 3'd0) begin
                miso   <= tx_next[7];
                tx_sh  <= {tx_next[6:0], 1'b0};
                tx_cnt <= 3'd7;
                if (state == RD_DATA) ptr <= ptr + MEM_AW'(1);
              end else begin
                miso   <= tx_sh[7];
                tx_sh  <= {tx_sh[6:0], 1'b0};
                tx_cnt <= tx_cnt - 3'd1;
              end
            end
          end

          WR_DATA: begin
            if (sck_rise) begin
              rx_sh   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                ptr     <= ptr + MEM_AW'(1);
                wrote   <= 1'b1;
              end
            end
          end

          IGNORE: begin
            // Any bit beyond the opcode disqualifies a pending WREN/WRDI.
            if (sck_rise) wel_op <= WEL_KEEP;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: directed scenarios plus a randomized
// command mix checked against a byte-array model of the flash.
module tb_spi_flash_responder;

  // Long enough that status polls and reads fit inside one busy window.
  localparam int BUSY = 1000;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic sck  = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe, wel, wip;

  int n_run  = 0;
  int n_fail = 0;

  logic [7:0] model_mem [256];
  logic       model_wel;
  logic [7:0] rd_buf [8];
  logic [7:0] wr_buf [8];
  logic       oe_seen;

  always #5 clk = ~clk;

  spi_flash_responder #(.MEM_AW(8), .BUSY_CYCLES(BUSY)) dut (
    .clk     (clk),
    .rst     (rst),
    .sck     (sck),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .miso    (miso),
    .miso_oe (miso_oe),
    .wel     (wel),
    .wip     (wip)
  );

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low;
    cs_n = 1'b0;
    clks(6);
  endtask

  task automatic cs_high;
    clks(6);
    cs_n = 1'b1;
    clks(8);
  endtask

  // Mode 0 master: set mosi while sck low, sample miso at the rising edge.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      clks(5);
      sck = 1'b1;
      rx[i] = miso;
      if (miso_oe === 1'b1) oe_seen = 1'b1;
      clks(5);
      sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic do_cmd(input logic [7:0] op);
    logic [7:0] rx;
    cs_low;
    spi_byte(op, rx);
    cs_high;
  endtask

  task automatic do_rdsr(output logic [7:0] st);
    logic [7:0] rx;
    cs_low;
    spi_byte(8'h05, rx);
    spi_byte(8'h00, st);
    cs_high;
  endtask

  task automatic send_addr(input logic [7:0] op, input logic [23:0] addr);
    logic [7:0] rx;
    spi_byte(op, rx);
    spi_byte(addr[23:16], rx);
    spi_byte(addr[15:8], rx);
    spi_byte(addr[7:0], rx);
  endtask

  task automatic do_read(input logic [23:0] addr, input int n);
    logic [7:0] rx;
    cs_low;
    send_addr(8'h03, addr);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, rx);
      rd_buf[i] = rx;
    end
    cs_high;
  endtask

  task automatic do_prog(input logic [23:0] addr, input int n, input int tail_bits,
                         input logic [7:0] tail);
    logic [7:0] rx;
    cs_low;
    send_addr(8'h02, addr);
    for (int i = 0; i < n; i++) spi_byte(wr_buf[i], rx);
    if (tail_bits > 0) spi_bits(tail, tail_bits, rx);
    cs_high;
  endtask

  // Flash rule: a program only lands if WEL was set; bytes wrap within the array.
  task automatic model_prog(input logic [23:0] addr, input int n);
    if (model_wel && n > 0) begin
      for (int i = 0; i < n; i++) model_mem[(int'(addr[7:0]) + i) % 256] = wr_buf[i];
      model_wel = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (wip === 1'b1 && k < BUSY + 200) begin
      @(negedge clk);
      k++;
    end
    n_run++;
    if (wip !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_timeout: wip=%b want 0", tag, wip);
    end
  endtask

  task automatic test_reset;
    clks(3);
    n_run += 4;
    if (miso !== 1'b0)    begin n_fail++; $display("FAIL reset_hold miso: got %b want 0", miso); end
    if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_hold miso_oe: got %b want 0", miso_oe); end
    if (wel !== 1'b0)     begin n_fail++; $display("FAIL reset_hold wel: got %b want 0", wel); end
    if (wip !== 1'b0)     begin n_fail++; $display("FAIL reset_hold wip: got %b want 0", wip); end
    rst = 1'b1;
    clks(6);
    n_run += 4;
    if (miso !== 1'b0)    begin n_fail++; $display("FAIL reset_rel miso: got %b want 0", miso); end
    if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_rel miso_oe: got %b want 0", miso_oe); end
    if (wel !== 1'b0)     begin n_fail++; $display("FAIL reset_rel wel: got %b want 0", wel); end
    if (wip !== 1'b0)     begin n_fail++; $display("FAIL reset_rel wip: got %b want 0", wip); end
  endtask

  task automatic test_read_after_reset;
    do_read(24'h000010, 2);
    for (int i = 0; i < 2; i++) begin
      n_run++;
      if (rd_buf[i] !== 8'hFF) begin
        n_fail++;
        $display("FAIL read_reset byte%0d: got %h want ff", i, rd_buf[i]);
      end
    end
    n_run += 2;
    if (wel !== 1'b0) begin n_fail++; $display("FAIL read_reset wel: got %b want 0", wel); end
    if (wip !== 1'b0) begin n_fail++; $display("FAIL read_reset wip: got %b want 0", wip); end
  endtask

  task automatic test_program_no_wren;
    wr_buf[0] = 8'hA5;
    do_prog(24'h000020, 1, 0, 8'h00);
    model_prog(24'h000020, 1);
    n_run++;
    if (wip !== 1'b0) begin n_fail++; $display("FAIL prog_no_wren wip: got %b want 0", wip); end
    do_read(24'h000020, 1);
    n_run++;
    if (rd_buf[0] !== model_mem[8'h20]) begin
      n_fail++;
      $display("FAIL prog_no_wren mem20: got %h want %h", rd_buf[0], model_mem[8'h20]);
    end
  endtask

  task automatic test_wren_program_busy;
    logic [7:0] st;
    logic [7:0] rx;
    int busy_len;
    do_cmd(8'h06);
    model_wel = 1'b1;
    do_rdsr(st);
    n_run++;
    if (st !== 8'h02) begin n_fail++; $display("FAIL wren_rdsr status: got %h want 02", st); end

    wr_buf[0] = 8'h11; wr_buf[1] = 8'h22; wr_buf[2] = 8'h33;
    cs_low;
    send_addr(8'h02, 24'h0000FE);
    for (int i = 0; i < 3; i++) spi_byte(wr_buf[i], rx);
    clks(6);
    cs_n = 1'b1;
    busy_len = 0;
    fork
      begin
        int k = 0;
        while (wip !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        while (wip === 1'b1 && busy_len < BUSY + 100) begin @(negedge clk); busy_len++; end
      end
      begin
        logic [7:0] s2;
        clks(14);
        do_rdsr(s2);
        n_run++;
        if (s2 !== 8'h03) begin n_fail++; $display("FAIL busy_rdsr status: got %h want 03", s2); end
        oe_seen = 1'b0;
        do_read(24'h000000, 1);
        n_run += 2;
        if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL busy_read miso_oe: got %b want 0", oe_seen); end
        if (wip !== 1'b1) begin n_fail++; $display("FAIL busy_window wip: got %b want 1", wip); end
      end
    join
    model_prog(24'h0000FE, 3);
    n_run++;
    if (busy_len != BUSY) begin
      n_fail++;
      $display("FAIL busy_len cycles: got %0d want %0d", busy_len, BUSY);
    end
    do_rdsr(st);
    n_run += 2;
    if (st !== 8'h00) begin n_fail++; $display("FAIL post_busy status: got %h want 00", st); end
    if (wel !== 1'b0) begin n_fail++; $display("FAIL post_busy wel: got %b want 0", wel); end
    do_read(24'h0000FE, 3);
    for (int i = 0; i < 3; i++) begin
      n_run++;
      if (rd_buf[i] !== model_mem[(254 + i) % 256]) begin
        n_fail++;
        $display("FAIL wrap_read byte%0d: got %h want %h", i, rd_buf[i], model_mem[(254 + i) % 256]);
      end
    end
  endtask

  task automatic test_partial_byte;
    do_cmd(8'h06);
    model_wel = 1'b1;
    do_prog(24'h000040, 0, 5, 8'hB7);
    model_prog(24'h000040, 0);
    n_run += 2;
    if (wip !== 1'b0) begin n_fail++; $display("FAIL partial_only wip: got %b want 0", wip); end
    if (wel !== model_wel) begin n_fail++; $display("FAIL partial_only wel: got %b want %b", wel, model_wel); end
    do_read(24'h000040, 1);
    n_run++;
    if (rd_buf[0] !== model_mem[8'h40]) begin
      n_fail++;
      $display("FAIL partial_only mem40: got %h want %h", rd_buf[0], model_mem[8'h40]);
    end

    wr_buf[0] = 8'h5A;
    do_prog(24'h000050, 1, 5, 8'hE0);
    model_prog(24'h000050, 1);
    n_run++;
    if (wip !== 1'b1) begin n_fail++; $display("FAIL partial_tail wip: got %b want 1", wip); end
    wait_idle("partial_tail");
    do_read(24'h000050, 2);
    for (int i = 0; i < 2; i++) begin
      n_run++;
      if (rd_buf[i] !== model_mem[8'h50 + i]) begin
        n_fail++;
        $display("FAIL partial_tail byte%0d: got %h want %h", i, rd_buf[i], model_mem[8'h50 + i]);
      end
    end
  endtask

  task automatic test_reset_mid_busy;
    do_cmd(8'h06);
    model_wel = 1'b1;
    wr_buf[0] = 8'hC3;
    do_prog(24'h000080, 1, 0, 8'h00);
    model_prog(24'h000080, 1);
    n_run++;
    if (wip !== 1'b1) begin n_fail++; $display("FAIL rst_busy pre wip: got %b want 1", wip); end
    rst = 1'b0;
    @(negedge clk);
    n_run += 3;
    if (wip !== 1'b0)     begin n_fail++; $display("FAIL rst_busy wip: got %b want 0", wip); end
    if (wel !== 1'b0)     begin n_fail++; $display("FAIL rst_busy wel: got %b want 0", wel); end
    if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL rst_busy miso_oe: got %b want 0", miso_oe); end
    rst = 1'b1;
    clks(50);
    n_run++;
    if (wip !== 1'b0) begin n_fail++; $display("FAIL rst_busy stays_idle wip: got %b want 0", wip); end
    do_read(24'h000080, 1);
    n_run++;
    if (rd_buf[0] !== model_mem[8'h80]) begin
      n_fail++;
      $display("FAIL rst_busy mem80: got %h want %h", rd_buf[0], model_mem[8'h80]);
    end
  endtask

  task automatic test_random;
    logic [7:0]  rx, st, op;
    logic [23:0] a;
    int          n, kind;
    for (int t = 0; t < 24; t++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0: begin do_cmd(8'h06); model_wel = 1'b1; end
        1: begin do_cmd(8'h04); model_wel = 1'b0; end
        2: begin
          // WREN/WRDI followed by extra bits must leave wel untouched.
          op = ($urandom_range(0, 1) != 0) ? 8'h06 : 8'h04;
          cs_low;
          spi_byte(op, rx);
          spi_bits(8'($urandom), int'($urandom_range(1, 8)), rx);
          cs_high;
          n_run++;
          if (wel !== model_wel) begin n_fail++; $display("FAIL rnd%0d long_wel: got %b want %b", t, wel, model_wel); end
        end
        3: begin
          if ($urandom_range(0, 1) != 0) begin do_cmd(8'h06); model_wel = 1'b1; end
          a = 24'($urandom);
          n = int'($urandom_range(1, 4));
          for (int i = 0; i < n; i++) wr_buf[i] = 8'($urandom);
          do_prog(a, n, 0, 8'h00);
          n_run++;
          if (wip !== model_wel) begin n_fail++; $display("FAIL rnd%0d prog_wip: got %b want %b", t, wip, model_wel); end
          model_prog(a, n);
          wait_idle("rnd_prog");
        end
        4: begin
          a = 24'($urandom);
          n = int'($urandom_range(1, 4));
          do_read(a, n);
          for (int i = 0; i < n; i++) begin
            n_run++;
            if (rd_buf[i] !== model_mem[(int'(a[7:0]) + i) % 256]) begin
              n_fail++;
              $display("FAIL rnd%0d read a=%h byte%0d: got %h want %h", t, a, i, rd_buf[i],
                       model_mem[(int'(a[7:0]) + i) % 256]);
            end
          end
        end
        default: begin
          do_rdsr(st);
          n_run++;
          if (st !== {6'b0, model_wel, 1'b0}) begin
            n_fail++;
            $display("FAIL rnd%0d rdsr: got %h want %h", t, st, {6'b0, model_wel, 1'b0});
          end
        end
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = 8'hFF;
    model_wel = 1'b0;
    oe_seen   = 1'b0;
    test_reset;
    test_read_after_reset;
    test_program_no_wren;
    test_wren_program_busy;
    test_partial_byte;
    test_reset_mid_busy;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
